mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL, default 4, cycles each channel select is held before its sample is taken; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a sweep; honoured only in IDLE.
REQ-005 cont  input  1  continuous mode; sampled in DONE.
REQ-006 abort  input  1  terminate the sweep; return to IDLE.
REQ-007 y  input  1  selected-bit output from the downstream 4:1 mux.
REQ-008 sel  output  2  channel select driven to the 4:1 mux.
REQ-009 busy  output  1  high in SCAN and DONE.
REQ-010 valid  output  1  one-cycle pulse; data_out holds a fresh complete sweep.
REQ-011 data_out  output  4  bit i = y sampled while sel == i.

Function
REQ-012 FSM states SHALL be IDLE, SCAN and DONE.
REQ-013 IDLE SHALL behave as follows: sel = 0, busy = 0, valid = 0; start = 1 -> SCAN, sel = 0, dwell counter = 0.
REQ-014 In SCAN, the dwell counter SHALL increment each cycle; when counter == DWELL-1, y SHALL be written to shadow[sel] and the counter SHALL clear.
REQ-015 At a sample edge with sel < 3, sel SHALL increment; with sel == 3, the state SHALL go to DONE and sel SHALL remain 3.
REQ-016 On DONE entry, shadow SHALL be copied to data_out; valid SHALL be high for exactly the one DONE cycle.
REQ-017 From DONE: cont = 1 -> SCAN with sel = 0 and counter = 0; cont = 0 -> IDLE.
REQ-018 Latency: valid SHALL go high after the 4*DWELL-th rising edge following the edge that sampled start.
REQ-019 In continuous mode, the valid period SHALL be 4*DWELL+1 cycles.
REQ-020 start SHALL be ignored while busy = 1; start and abort asserted together in IDLE SHALL leave the block in IDLE.
REQ-021 abort in SCAN or DONE SHALL force IDLE and sel = 0 at the next edge.
REQ-022 An abort in DONE SHALL NOT suppress the valid pulse for that cycle, because valid is already asserted.
REQ-023 An abort in SCAN SHALL NOT update data_out and SHALL NOT pulse valid.
REQ-024 data_out SHALL hold its value between valid pulses, including across abort; partial sweeps SHALL never be visible.
REQ-025 For DWELL = 1, the block SHALL sample every cycle, and sel SHALL step 0,1,2,3 on consecutive cycles.
REQ-026 The dwell counter SHALL be 8 bits wide and SHALL never exceed DWELL-1.
REQ-027 sel SHALL change only on dwell boundaries, which gives the mux input DWELL-1 settle cycles before each sample.

Reset
REQ-028 rst = 1 SHALL put the block in IDLE, with sel = 0, busy = 0, valid = 0, data_out = 0, shadow = 0 and counter = 0 after the edge.
REQ-029 rst SHALL override start, abort and cont in the same cycle.
REQ-030 Reset mid-sweep SHALL discard the partial shadow.

Structure
REQ-031 A shared package, mux_scan_pkg, SHALL hold the state encoding (IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2), the select width (2) and the channel count (4).
REQ-032 One sub-module, dwell_counter, SHALL be used; it has clear and enable inputs and a terminal-count output equal to (count == DWELL-1).
REQ-033 The top level SHALL contain the FSM, the sel register, the shadow register and the data_out register.
REQ-034 The block SHALL be synthesizable with no latches and no combinational path from y to any output.

Verification
REQ-035 Reset and single sweep: DWELL = 2, y driven from a mux with in = 4'b1010 -> valid pulses 8 edges after start, data_out = 4'b1010, then IDLE with busy = 0.
REQ-036 Continuous sweep: DWELL = 1, cont = 1, in switched from 4'b0110 to 4'b1001 between sweeps -> valid every 5 cycles, data_out = 4'b0110 then 4'b1001.
REQ-037 Abort in SCAN: abort asserted while sel = 2 -> next cycle IDLE, sel = 0, no valid pulse, data_out keeps its previous value.
REQ-038 Start ignored while busy: start pulsed during SCAN -> sweep timing unchanged, exactly one valid pulse.
REQ-039 Reset mid-sweep: rst asserted when sel = 1 -> all outputs 0 next cycle; a new start gives a correct full sweep.
REQ-040 Dwell timing: DWELL = 4 -> sel holds 0 for 4 cycles, then 1, 2 and 3 for 4 cycles each; the sample of y is taken on the 4th cycle of each channel.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: state encoding,
// select width, channel count and dwell counter width.
package mux_scan_pkg;

  localparam int SEL_W = 2;
  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Control/status bundle between the scan controller and its environment.
//
// Handshake: start, abort and cont are level inputs sampled on the rising
// edge. valid is a one-cycle pulse with no ready; data_out is stable from
// that pulse until the next one. There is no backpressure.
//
// state is a read-only debug view of the controller FSM.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic             start;
  logic             cont;
  logic             abort;
  logic             y;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             valid;
  logic [N_CH-1:0]  data_out;
  state_t           state;

  modport master (
    output start, cont, abort, y,
    input  sel, busy, valid, data_out, state
  );

  modport slave (
    input  start, cont, abort, y,
    output sel, busy, valid, data_out, state
  );

endinterface

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Dwell counter: counts enabled cycles and flags the last cycle of a dwell.
// clr has priority over en; the count wraps to 0 through clr at terminal
// count, so it never exceeds DWELL-1.
module dwell_counter
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; clear on reset or explicit clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4:1 mux. Steps sel through all four
// channels, holds each for DWELL cycles so the mux output can settle, and
// samples y on the last cycle of each dwell. A complete sweep is published
// on data_out together with a one-cycle valid pulse.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input logic           clk,
  input logic           rst,
  mux_scan_ctrl_if.slave bus
);

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             valid;
  logic [N_CH-1:0]  shadow;
  logic [N_CH-1:0]  next_shadow;
  logic [N_CH-1:0]  data_out;
  logic             tc;
  logic             cnt_en;
  logic             cnt_clr;

  // The counter only runs in SCAN; it restarts at every dwell boundary and
  // whenever the sweep is abandoned.
  assign cnt_en  = (state == SCAN);
  assign cnt_clr = (state != SCAN) || tc || bus.abort;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (tc)
  );

  // Shadow with the current channel's bit replaced by y; lets the final
  // sample land in data_out on the same edge it is taken.
  always_comb begin
    next_shadow      = shadow;
    next_shadow[sel] = bus.y;
  end

  // Sweep FSM with sel, shadow and data_out registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      shadow   <= '0;
      data_out <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          sel  <= '0;
          busy <= 1'b0;
          if (bus.start && !bus.abort) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (bus.abort) begin
            state <= IDLE;
            sel   <= '0;
            busy  <= 1'b0;
          end else if (tc) begin
            shadow <= next_shadow;
            if (sel == SEL_W'(N_CH - 1)) begin
              state    <= DONE;
              valid    <= 1'b1;
              data_out <= next_shadow;
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end
        end
        DONE: begin
          sel <= '0;
          if (bus.cont && !bus.abort) begin
            state <= SCAN;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel      = sel;
  assign bus.busy     = busy;
  assign bus.valid    = valid;
  assign bus.data_out = data_out;
  assign bus.state    = state;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl. Three instances (DWELL = 2, 1, 4) share clk/rst
// and have independent controls; each y comes from a modelled 4:1 mux.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus / observation signals ----------------
  logic [2:0] start_v, cont_v, abort_v;
  logic [3:0] in_v   [3];
  logic [1:0] sel_v  [3];
  logic [3:0] dout_v [3];
  state_t     st_v   [3];
  logic [2:0] busy_v, valid_v;

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt [3] = '{0, 0, 0};

  mux_scan_ctrl_if if0 ();
  mux_scan_ctrl_if if1 ();
  mux_scan_ctrl_if if2 ();

  assign if0.start = start_v[0]; assign if0.cont = cont_v[0];
  assign if0.abort = abort_v[0]; assign if0.y = in_v[0][if0.sel];
  assign if1.start = start_v[1]; assign if1.cont = cont_v[1];
  assign if1.abort = abort_v[1]; assign if1.y = in_v[1][if1.sel];
  assign if2.start = start_v[2]; assign if2.cont = cont_v[2];
  assign if2.abort = abort_v[2]; assign if2.y = in_v[2][if2.sel];

  assign sel_v[0] = if0.sel; assign dout_v[0] = if0.data_out; assign st_v[0] = if0.state;
  assign sel_v[1] = if1.sel; assign dout_v[1] = if1.data_out; assign st_v[1] = if1.state;
  assign sel_v[2] = if2.sel; assign dout_v[2] = if2.data_out; assign st_v[2] = if2.state;
  assign busy_v  = {if2.busy, if1.busy, if0.busy};
  assign valid_v = {if2.valid, if1.valid, if0.valid};

  mux_scan_ctrl #(.DWELL(2)) u0 (.clk(clk), .rst(rst), .bus(if0));
  mux_scan_ctrl #(.DWELL(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  mux_scan_ctrl #(.DWELL(4)) u2 (.clk(clk), .rst(rst), .bus(if2));

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int         cyc_q0[$], cyc_q1[$], cyc_q2[$];

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d] @cyc %0d: got %0h, expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [3:0] d, input int c);
    case (k)
      0: begin exp_q0.push_back(d); cyc_q0.push_back(c); end
      1: begin exp_q1.push_back(d); cyc_q1.push_back(c); end
      default: begin exp_q2.push_back(d); cyc_q2.push_back(c); end
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic pop(input int k, output logic [3:0] d, output int c);
    case (k)
      0: begin d = exp_q0.pop_front(); c = cyc_q0.pop_front(); end
      1: begin d = exp_q1.pop_front(); c = cyc_q1.pop_front(); end
      default: begin d = exp_q2.pop_front(); c = cyc_q2.pop_front(); end
    endcase
  endtask

  // Monitor: every valid pulse must match the next expected sweep and cycle.
  logic [3:0] mon_d;
  int         mon_c;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int k = 0; k < 3; k++) begin
        if (valid_v[k] === 1'b1) begin
          vcnt[k]++;
          if (qsize(k) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid[u%0d] @cyc %0d: got data %b, expected no pulse",
                     k, cyc, dout_v[k]);
          end else begin
            pop(k, mon_d, mon_c);
            check("valid_data", k, 32'(dout_v[k]), 32'(mon_d));
            check("valid_cycle", k, cyc, mon_c);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int k, input int limit);
    int n;
    n = 0;
    while (busy_v[k] !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    if (busy_v[k] !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout[u%0d]: busy still %b after %0d cycles, expected 0", k, busy_v[k], limit);
    end
  endtask

  task automatic wait_sel(input int k, input logic [1:0] s, input int limit);
    int n;
    n = 0;
    while (sel_v[k] !== s && n < limit) begin
      tick();
      n++;
    end
    check("wait_sel", k, 32'(sel_v[k]), 32'(s));
  endtask

  task automatic check_cleared(input string name, input int k, input logic [3:0] dexp);
    check({name, "_busy"}, k, 32'(busy_v[k]), 0);
    check({name, "_sel"}, k, 32'(sel_v[k]), 0);
    check({name, "_valid"}, k, 32'(valid_v[k]), 0);
    check({name, "_dout"}, k, 32'(dout_v[k]), 32'(dexp));
    check({name, "_state"}, k, 32'(st_v[k]), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e;
    int v_before;
    logic [3:0] want;

    // Reset with every control asserted: reset must win.
    rst     = 1'b1;
    start_v = 3'b111;
    cont_v  = 3'b111;
    abort_v = 3'b000;
    for (int k = 0; k < 3; k++) in_v[k] = 4'b1111;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) check_cleared("reset", k, 4'b0000);
    rst     = 1'b0;
    start_v = 3'b000;
    cont_v  = 3'b000;
    tick();

    // Single sweep, DWELL = 2: valid 8 edges after start, then IDLE.
    in_v[0]    = 4'b1010;
    start_v[0] = 1'b1;
    e          = cyc + 1;
    push(0, 4'b1010, e + 8);
    tick();
    start_v[0] = 1'b0;
    check("busy_after_start", 0, 32'(busy_v[0]), 1);
    wait_idle(0, 40);
    check("idle_cycle", 0, cyc, e + 9);
    check_cleared("after_sweep", 0, 4'b1010);

    // Continuous, DWELL = 1: sel steps every cycle, valid every 5 cycles.
    in_v[1]    = 4'b0110;
    start_v[1] = 1'b1;
    cont_v[1]  = 1'b1;
    e          = cyc + 1;
    push(1, 4'b0110, e + 4);
    push(1, 4'b1001, e + 9);
    tick();
    start_v[1] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("dwell1_sel", 1, 32'(sel_v[1]), j);
      tick();
    end
    in_v[1] = 4'b1001;
    while (cyc < e + 9) tick();
    cont_v[1] = 1'b0;
    wait_idle(1, 20);
    check("cont_stop_cycle", 1, cyc, e + 10);

    // Abort in SCAN at sel = 2: no pulse, data_out keeps 1010.
    in_v[0]    = 4'b0101;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_sel(0, 2'd2, 20);
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    check_cleared("abort_scan", 0, 4'b1010);
    repeat (6) tick();

    // Abort in DONE with cont set: pulse still seen, abort beats cont.
    in_v[0]    = 4'b0011;
    cont_v[0]  = 1'b1;
    start_v[0] = 1'b1;
    e          = cyc + 1;
    push(0, 4'b0011, e + 8);
    tick();
    start_v[0] = 1'b0;
    while (cyc < e + 8) tick();
    check("valid_in_done", 0, 32'(valid_v[0]), 1);
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    cont_v[0]  = 1'b0;
    check_cleared("abort_done", 0, 4'b0011);

    // DWELL = 4: sel holds 4 cycles per channel, y taken on the 4th cycle
    // (y is wrong on cycles 1..3), and a start during SCAN is ignored.
    want       = 4'b1100;
    in_v[2]    = ~want;
    start_v[2] = 1'b1;
    e          = cyc + 1;
    v_before   = vcnt[2];
    push(2, want, e + 16);
    tick();
    for (int j = 0; j < 16; j++) begin
      check("dwell4_sel", 2, 32'(sel_v[2]), j / 4);
      start_v[2] = (j == 5);
      in_v[2]    = (j % 4 == 3) ? want : ~want;
      tick();
    end
    start_v[2] = 1'b0;
    in_v[2]    = want;
    wait_idle(2, 10);
    check("single_valid", 2, vcnt[2] - v_before, 1);
    check("dwell4_idle_cycle", 2, cyc, e + 17);

    // start and abort together in IDLE: stay in IDLE.
    start_v[1] = 1'b1;
    abort_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    abort_v[1] = 1'b0;
    check_cleared("start_abort_idle", 1, 4'b1001);

    // Reset mid-sweep at sel = 1, then a clean full sweep.
    in_v[0]    = 4'b1110;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_sel(0, 2'd1, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("mid_reset", 0, 4'b0000);
    start_v[0] = 1'b1;
    e          = cyc + 1;
    push(0, 4'b1110, e + 8);
    tick();
    start_v[0] = 1'b0;
    wait_idle(0, 40);
    check("post_reset_dout", 0, 32'(dout_v[0]), 32'(4'b1110));

    // Every expected pulse must have been consumed.
    repeat (5) tick();
    for (int k = 0; k < 3; k++) check("queue_drained", k, qsize(k), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
